// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the pipeline: instruction codes, status codes,
// register ids and the writeback status-machine states.
package y86_pkg;

   localparam logic [3:0] ICODE_HALT   = 4'h0;
   localparam logic [3:0] ICODE_NOP    = 4'h1;
   localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
   localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
   localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
   localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
   localparam logic [3:0] ICODE_OPQ    = 4'h6;
   localparam logic [3:0] ICODE_JXX    = 4'h7;
   localparam logic [3:0] ICODE_CALL   = 4'h8;
   localparam logic [3:0] ICODE_RET    = 4'h9;
   localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
   localparam logic [3:0] ICODE_POPQ   = 4'hB;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   localparam logic [3:0] REG_RSP  = 4'h4;
   localparam logic [3:0] REG_NONE = 4'hF;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } wb_state_t;

   // A data-memory fault overrides whatever status the instruction carried.
   function automatic logic [2:0] resolve_stat(input logic [2:0] stat, input logic dmem_error);
      return dmem_error ? STAT_ADR : stat;
   endfunction

endpackage

// File: rtl/wb_pipe_reg.sv
// W pipeline register: holds the memory-stage result for writeback, with
// hold (stall/halt), bubble insertion and asynchronous reset to a bubble.
module wb_pipe_reg
   import y86_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int REG_AW = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hold,
   input  logic              bubble,
   input  logic              vld,
   input  logic [3:0]        icode,
   input  logic [2:0]        stat,
   input  logic [REG_AW-1:0] dst_e,
   input  logic [REG_AW-1:0] dst_m,
   input  logic [DATA_W-1:0] val_e,
   input  logic [DATA_W-1:0] val_m,
   output logic              vld_p1,
   output logic [3:0]        icode_p1,
   output logic [2:0]        stat_p1,
   output logic [REG_AW-1:0] dst_e_p1,
   output logic [REG_AW-1:0] dst_m_p1,
   output logic [DATA_W-1:0] val_e_p1,
   output logic [DATA_W-1:0] val_m_p1
);

   // M -> W boundary; hold outranks bubble so a stalled slot is never lost
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1   <= 1'b0;
         icode_p1 <= ICODE_NOP;
         stat_p1  <= STAT_AOK;
         dst_e_p1 <= '1;
         dst_m_p1 <= '1;
         val_e_p1 <= '0;
         val_m_p1 <= '0;
      end else if (hold) begin
         vld_p1   <= vld_p1;
      end else if (bubble) begin
         vld_p1   <= 1'b0;
         icode_p1 <= ICODE_NOP;
         stat_p1  <= STAT_AOK;
         dst_e_p1 <= '1;
         dst_m_p1 <= '1;
         val_e_p1 <= '0;
         val_m_p1 <= '0;
      end else begin
         vld_p1   <= vld;
         icode_p1 <= icode;
         stat_p1  <= stat;
         dst_e_p1 <= dst_e;
         dst_m_p1 <= dst_m;
         val_e_p1 <= val_e;
         val_m_p1 <= val_m;
      end
   end

endmodule

// File: rtl/writeback_stage.sv
// Y86-64 writeback stage: W register, register-file write ports and forwarding
// taps, sticky halt status machine and saturating retired-instruction counter.
module writeback_stage
   import y86_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int REG_AW = 4,
   parameter int CNT_W  = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              stall_i,
   input  logic              bubble_i,
   input  logic              valid_i,
   input  logic [3:0]        icode_i,
   input  logic [2:0]        stat_i,
   input  logic              dmem_error_i,
   input  logic [DATA_W-1:0] valE_i,
   input  logic [DATA_W-1:0] valM_i,
   input  logic [REG_AW-1:0] dstE_i,
   input  logic [REG_AW-1:0] dstM_i,
   output logic              rf_we_e_o,
   output logic [REG_AW-1:0] rf_addr_e_o,
   output logic [DATA_W-1:0] rf_data_e_o,
   output logic              rf_we_m_o,
   output logic [REG_AW-1:0] rf_addr_m_o,
   output logic [DATA_W-1:0] rf_data_m_o,
   output logic [2:0]        w_stat_o,
   output logic [2:0]        stat_o,
   output logic              halted_o,
   output logic [CNT_W-1:0]  retired_o
);

   localparam logic [REG_AW-1:0] W_REG_NONE = '1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      return (&cnt) ? cnt : cnt + CNT_W'(1);
   endfunction

   logic              vld_p1;
   logic [3:0]        icode_p1;
   logic [2:0]        stat_p1;
   logic [REG_AW-1:0] dst_e_p1;
   logic [REG_AW-1:0] dst_m_p1;
   logic [DATA_W-1:0] val_e_p1;
   logic [DATA_W-1:0] val_m_p1;

   wb_state_t         state_q;
   wb_state_t         state_d;
   logic [2:0]        stat_q;
   logic [2:0]        stat_d;
   logic [CNT_W-1:0]  retired_q;
   logic              halted;
   logic              w_live;
   logic              unused_icode;

   assign halted = (state_q == ST_HALTED);

   wb_pipe_reg #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_pipe_reg (
      .clk      (clk_i),
      .rst      (rst_i),
      .hold     (halted | stall_i),
      .bubble   (bubble_i),
      .vld      (valid_i),
      .icode    (icode_i),
      .stat     (resolve_stat(stat_i, dmem_error_i)),
      .dst_e    (dstE_i),
      .dst_m    (dstM_i),
      .val_e    (valE_i),
      .val_m    (valM_i),
      .vld_p1   (vld_p1),
      .icode_p1 (icode_p1),
      .stat_p1  (stat_p1),
      .dst_e_p1 (dst_e_p1),
      .dst_m_p1 (dst_m_p1),
      .val_e_p1 (val_e_p1),
      .val_m_p1 (val_m_p1)
   );

   // Icode travels with the slot for debug visibility only.
   assign unused_icode = ^icode_p1;

   // W stage outputs: a live slot is a real, healthy instruction while running
   assign w_live      = vld_p1 & (stat_p1 == STAT_AOK) & ~halted;
   assign rf_we_m_o   = w_live & (dst_m_p1 != W_REG_NONE);
   assign rf_we_e_o   = w_live & (dst_e_p1 != W_REG_NONE)
                        & ~((dst_e_p1 == dst_m_p1) & rf_we_m_o);
   assign rf_addr_e_o = dst_e_p1;
   assign rf_data_e_o = val_e_p1;
   assign rf_addr_m_o = dst_m_p1;
   assign rf_data_m_o = val_m_p1;
   assign w_stat_o    = stat_p1;
   assign stat_o      = stat_q;
   assign halted_o    = halted;
   assign retired_o   = retired_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_RUN;
         stat_q  <= STAT_AOK;
      end else begin
         state_q <= state_d;
         stat_q  <= stat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      stat_d  = stat_q;
      case (state_q)
         ST_RUN: begin
            if (vld_p1 && (stat_p1 != STAT_AOK)) begin
               state_d = ST_HALTED;
               stat_d  = stat_p1;
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // A stalled instruction is counted only on the edge that moves it out of W.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         retired_q <= '0;
      end else if (w_live && !stall_i) begin
         retired_q <= sat_inc(retired_q);
      end
   end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed vector table, hand-built halt/reset
// sequences and a randomized run against an instruction-level reference model.
module tb_writeback_stage;
   import y86_pkg::*;

   localparam int DATA_W = 64;
   localparam int REG_AW = 4;
   localparam int CNT_W  = 2;
   localparam logic       O  = 1'b0;
   localparam logic       I  = 1'b1;
   localparam logic [3:0] RN = 4'hF;

   logic              clk = 1'b0;
   logic              rst_i = 1'b1;
   logic              stall_i = 1'b0, bubble_i = 1'b0, valid_i = 1'b0, dmem_error_i = 1'b0;
   logic [3:0]        icode_i = ICODE_NOP;
   logic [2:0]        stat_i = STAT_AOK;
   logic [DATA_W-1:0] valE_i = '0, valM_i = '0;
   logic [REG_AW-1:0] dstE_i = RN, dstM_i = RN;
   logic              rf_we_e_o, rf_we_m_o, halted_o;
   logic [REG_AW-1:0] rf_addr_e_o, rf_addr_m_o;
   logic [DATA_W-1:0] rf_data_e_o, rf_data_m_o;
   logic [2:0]        w_stat_o, stat_o;
   logic [CNT_W-1:0]  retired_o;

   always #5 clk = ~clk;

   writeback_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .bubble_i(bubble_i),
      .valid_i(valid_i), .icode_i(icode_i), .stat_i(stat_i), .dmem_error_i(dmem_error_i),
      .valE_i(valE_i), .valM_i(valM_i), .dstE_i(dstE_i), .dstM_i(dstM_i),
      .rf_we_e_o(rf_we_e_o), .rf_addr_e_o(rf_addr_e_o), .rf_data_e_o(rf_data_e_o),
      .rf_we_m_o(rf_we_m_o), .rf_addr_m_o(rf_addr_m_o), .rf_data_m_o(rf_data_m_o),
      .w_stat_o(w_stat_o), .stat_o(stat_o), .halted_o(halted_o), .retired_o(retired_o)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: the instruction sitting in W plus machine status.
   typedef struct packed {
      logic        vld;
      logic [2:0]  stat;
      logic [3:0]  de;
      logic [3:0]  dm;
      logic [63:0] ve;
      logic [63:0] vm;
   } winst_t;

   winst_t      m_w;
   logic        m_halted;
   logic [2:0]  m_stat;
   int unsigned m_ret;

   task automatic model_reset();
      m_w      = '{vld: 1'b0, stat: STAT_AOK, de: RN, dm: RN, ve: 64'h0, vm: 64'h0};
      m_halted = 1'b0;
      m_stat   = STAT_AOK;
      m_ret    = 0;
   endtask

   task automatic model_edge();
      logic faulted;
      faulted = m_w.vld && (m_w.stat != STAT_AOK);
      if (!m_halted) begin
         if (m_w.vld && m_w.stat == STAT_AOK && !stall_i) m_ret++;
         if (faulted) m_stat = m_w.stat;
         if (stall_i) begin
            m_w = m_w;
         end else if (bubble_i) begin
            m_w = '{vld: 1'b0, stat: STAT_AOK, de: RN, dm: RN, ve: 64'h0, vm: 64'h0};
         end else begin
            m_w = '{vld: valid_i, stat: dmem_error_i ? STAT_ADR : stat_i,
                    de: dstE_i, dm: dstM_i, ve: valE_i, vm: valM_i};
         end
         m_halted = faulted;
      end
   endtask

   task automatic check_model(input string tag);
      logic        healthy, exp_we_m, exp_we_e;
      int unsigned cap;
      healthy  = m_w.vld && m_w.stat == STAT_AOK && !m_halted;
      exp_we_m = healthy && m_w.dm != RN;
      // Same destination on both ports: the memory value is the one that lands.
      exp_we_e = healthy && m_w.de != RN && !(exp_we_m && m_w.de == m_w.dm);
      cap = (1 << CNT_W) - 1;
      chk({tag, ".we_e"},    64'(rf_we_e_o),   64'(exp_we_e));
      chk({tag, ".addr_e"},  64'(rf_addr_e_o), 64'(m_w.de));
      chk({tag, ".data_e"},  rf_data_e_o,      m_w.ve);
      chk({tag, ".we_m"},    64'(rf_we_m_o),   64'(exp_we_m));
      chk({tag, ".addr_m"},  64'(rf_addr_m_o), 64'(m_w.dm));
      chk({tag, ".data_m"},  rf_data_m_o,      m_w.vm);
      chk({tag, ".w_stat"},  64'(w_stat_o),    64'(m_w.stat));
      chk({tag, ".stat"},    64'(stat_o),      64'(m_stat));
      chk({tag, ".halted"},  64'(halted_o),    64'(m_halted));
      chk({tag, ".retired"}, 64'(retired_o),   64'((m_ret > cap) ? cap : m_ret));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic set_in(input logic st, input logic bu, input logic va, input logic [3:0] ic,
                         input logic [2:0] sa, input logic de_err, input logic [63:0] ve,
                         input logic [63:0] vm, input logic [3:0] de, input logic [3:0] dm);
      stall_i = st; bubble_i = bu; valid_i = va; icode_i = ic; stat_i = sa;
      dmem_error_i = de_err; valE_i = ve; valM_i = vm; dstE_i = de; dstM_i = dm;
   endtask

   task automatic pulse_reset();
      #2 rst_i = 1'b1;
      model_reset();
      #1 check_model("async_rst");
      #1 rst_i = 1'b0;
   endtask

   typedef struct packed {
      logic        st, bu, va;
      logic [3:0]  ic;
      logic [2:0]  sa;
      logic        derr;
      logic [63:0] ve, vm;
      logic [3:0]  de, dm;
      logic        x_we_e;
      logic [3:0]  x_a_e;
      logic [63:0] x_d_e;
      logic        x_we_m;
      logic [3:0]  x_a_m;
      logic [63:0] x_d_m;
      logic [2:0]  x_ws, x_st;
      logic        x_h;
      logic [1:0]  x_ret;
   } vec_t;

   vec_t vt [11];

   initial begin
      vt[0]  = '{O,O,I,ICODE_IRMOVQ,STAT_AOK,O,64'h55,64'h0,4'd0,RN,
                 I,4'd0,64'h55,O,RN,64'h0,STAT_AOK,STAT_AOK,O,2'd0};
      vt[1]  = '{O,O,I,ICODE_POPQ,STAT_AOK,O,64'h100,64'h7,REG_RSP,REG_RSP,
                 O,REG_RSP,64'h100,I,REG_RSP,64'h7,STAT_AOK,STAT_AOK,O,2'd1};
      vt[2]  = '{O,O,I,ICODE_OPQ,STAT_AOK,O,64'h11,64'h0,4'd6,RN,
                 I,4'd6,64'h11,O,RN,64'h0,STAT_AOK,STAT_AOK,O,2'd2};
      vt[3]  = '{O,O,I,ICODE_RRMOVQ,STAT_AOK,O,64'h22,64'h0,4'd7,RN,
                 I,4'd7,64'h22,O,RN,64'h0,STAT_AOK,STAT_AOK,O,2'd3};
      vt[4]  = '{O,O,I,ICODE_MRMOVQ,STAT_AOK,O,64'h20,64'hAB,RN,4'd3,
                 O,RN,64'h20,I,4'd3,64'hAB,STAT_AOK,STAT_AOK,O,2'd3};
      for (int k = 5; k < 8; k++)
         vt[k] = '{I,I,I,ICODE_IRMOVQ,STAT_AOK,O,64'h99,64'h0,4'd1,RN,
                   O,RN,64'h20,I,4'd3,64'hAB,STAT_AOK,STAT_AOK,O,2'd3};
      vt[8]  = '{O,O,I,ICODE_HALT,STAT_HLT,O,64'h0,64'h0,RN,RN,
                 O,RN,64'h0,O,RN,64'h0,STAT_HLT,STAT_AOK,O,2'd3};
      vt[9]  = '{O,O,I,ICODE_IRMOVQ,STAT_AOK,O,64'h77,64'h0,4'd2,RN,
                 O,4'd2,64'h77,O,RN,64'h0,STAT_AOK,STAT_HLT,I,2'd3};
      vt[10] = '{O,O,I,ICODE_IRMOVQ,STAT_AOK,O,64'h88,64'h0,4'd5,RN,
                 O,4'd2,64'h77,O,RN,64'h0,STAT_AOK,STAT_HLT,I,2'd3};

      model_reset();
      repeat (2) @(negedge clk);
      rst_i = 1'b0;
      check_model("reset");

      // Directed vectors: writes, popq conflict, saturation, stall+bubble, halt.
      for (int k = 0; k < 11; k++) begin
         set_in(vt[k].st, vt[k].bu, vt[k].va, vt[k].ic, vt[k].sa, vt[k].derr,
                vt[k].ve, vt[k].vm, vt[k].de, vt[k].dm);
         cycle();
         chk($sformatf("vec%0d.we_e", k),    64'(rf_we_e_o),   64'(vt[k].x_we_e));
         chk($sformatf("vec%0d.addr_e", k),  64'(rf_addr_e_o), 64'(vt[k].x_a_e));
         chk($sformatf("vec%0d.data_e", k),  rf_data_e_o,      vt[k].x_d_e);
         chk($sformatf("vec%0d.we_m", k),    64'(rf_we_m_o),   64'(vt[k].x_we_m));
         chk($sformatf("vec%0d.addr_m", k),  64'(rf_addr_m_o), 64'(vt[k].x_a_m));
         chk($sformatf("vec%0d.data_m", k),  rf_data_m_o,      vt[k].x_d_m);
         chk($sformatf("vec%0d.w_stat", k),  64'(w_stat_o),    64'(vt[k].x_ws));
         chk($sformatf("vec%0d.stat", k),    64'(stat_o),      64'(vt[k].x_st));
         chk($sformatf("vec%0d.halted", k),  64'(halted_o),    64'(vt[k].x_h));
         chk($sformatf("vec%0d.retired", k), 64'(retired_o),   64'(vt[k].x_ret));
      end

      // Asynchronous reset while halted, then a fresh irmovq.
      chk("pre_rst.retired", 64'(retired_o), 64'd3);
      #2 rst_i = 1'b1;
      #1;
      chk("rst.we_e",    64'(rf_we_e_o),   64'd0);
      chk("rst.we_m",    64'(rf_we_m_o),   64'd0);
      chk("rst.addr_e",  64'(rf_addr_e_o), 64'hF);
      chk("rst.data_m",  rf_data_m_o,      64'h0);
      chk("rst.w_stat",  64'(w_stat_o),    64'(STAT_AOK));
      chk("rst.stat",    64'(stat_o),      64'(STAT_AOK));
      chk("rst.halted",  64'(halted_o),    64'd0);
      chk("rst.retired", 64'(retired_o),   64'd0);
      #1 rst_i = 1'b0;
      model_reset();
      set_in(O, O, I, ICODE_IRMOVQ, STAT_AOK, O, 64'hABC, 64'h0, 4'd1, RN);
      cycle();
      chk("fresh.we_e",   64'(rf_we_e_o),   64'd1);
      chk("fresh.addr_e", 64'(rf_addr_e_o), 64'd1);
      chk("fresh.data_e", rf_data_e_o,      64'hABC);

      // Data-memory fault on an otherwise healthy mrmovq.
      set_in(O, O, I, ICODE_MRMOVQ, STAT_AOK, I, 64'h8, 64'h5A, RN, 4'd3);
      cycle();
      chk("dmem.w_stat", 64'(w_stat_o),  64'(STAT_ADR));
      chk("dmem.we_m",   64'(rf_we_m_o), 64'd0);
      chk("dmem.halted", 64'(halted_o),  64'd0);
      set_in(O, I, O, ICODE_NOP, STAT_AOK, O, 64'h0, 64'h0, RN, RN);
      cycle();
      chk("dmem.stat_after",   64'(stat_o),    64'(STAT_ADR));
      chk("dmem.halted_after", 64'(halted_o),  64'd1);
      chk("dmem.retired",      64'(retired_o), 64'd1);

      pulse_reset();

      // Randomized run against the model.
      for (int c = 0; c < 2000; c++) begin
         logic [5:0] r;
         logic [3:0] de, dm;
         r  = 6'($urandom_range(0, 63));
         de = ($urandom_range(0, 4) == 0) ? RN : 4'($urandom_range(0, 15));
         dm = ($urandom_range(0, 2) == 0) ? RN : 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) dm = de;
         set_in(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 7) != 0), 4'($urandom_range(0, 11)),
                (r == 0) ? STAT_HLT : (r == 1) ? STAT_INS : (r == 2) ? STAT_ADR : STAT_AOK,
                ($urandom_range(0, 47) == 0),
                {$urandom, $urandom}, {$urandom, $urandom}, de, dm);
         cycle();
         check_model($sformatf("rand%0d", c));
         if (m_halted && $urandom_range(0, 7) == 0) pulse_reset();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
